// File: rtl/uart_word_tx.sv
// uart_word_tx: sends a fixed ASCII word as back-to-back UART frames, one
// start request per word. Frames are 8N1 by default; defining the macro
// UART_TX_PARITY_EN inserts an even-parity bit before the stop bit (8E1).
// Contains a baud-interval counter, a bit-serialiser FSM and a byte sequencer.
module uart_word_tx #(
    parameter int unsigned          CLK_SPEED = 50_000_000,
    parameter int unsigned          BAUD      = 115_200,
    parameter int unsigned          WORD_LEN  = 4,
    parameter logic [8*WORD_LEN-1:0] WORD     = "HELO",
    parameter int unsigned          WIDTH     = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    output logic                              tx,
    output logic                              busy,
    output logic                              done,
    output logic [$clog2(WORD_LEN+1)-1:0]     byte_idx
);

    localparam int unsigned IDX_W = $clog2(WORD_LEN + 1);
    localparam int unsigned DIV   = CLK_SPEED / BAUD;
    localparam logic [WIDTH-1:0] DIV_M1   = WIDTH'(DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   baud_q;
    logic [WIDTH-1:0]   baud_d;
    logic [2:0]         bit_q;
    logic [7:0]         shift_q;
    logic               tx_q;
    logic               busy_q;
    logic               done_q;
    logic [IDX_W-1:0]   idx_q;
`ifdef UART_TX_PARITY_EN
    logic               par_q;
`endif

    logic               bit_end_c;
    logic               last_char_c;
    logic [7:0]         first_char_c;
    logic [7:0]         next_char_c;

    // Character k of WORD, leftmost character is k = 0.
    function automatic logic [7:0] char_at(input logic [IDX_W-1:0] idx);
        logic [8*WORD_LEN-1:0] w;
        w = WORD >> (8 * (WORD_LEN - 1 - 32'(idx)));
        return w[7:0];
    endfunction

    // Baud counter next value and sequencer lookups.
    always_comb begin
        bit_end_c    = (baud_q == DIV_M1);
        last_char_c  = (idx_q == LAST_IDX);
        first_char_c = char_at(IDX_W'(0));
        next_char_c  = char_at(idx_q + IDX_W'(1));
        baud_d       = baud_q + WIDTH'(1);
        if (state_q == S_IDLE || bit_end_c) begin
            baud_d = '0;
        end
    end

    // Serialiser FSM with registered line, status and character index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            baud_q <= baud_d;
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (start) begin
                        state_q <= S_START;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        idx_q   <= '0;
                        shift_q <= first_char_c;
`ifdef UART_TX_PARITY_EN
                        par_q   <= ^first_char_c;
`endif
                    end
                end
                S_START: begin
                    if (bit_end_c) begin
                        state_q <= S_DATA;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                    end
                end
                S_DATA: begin
                    if (bit_end_c) begin
                        if (bit_q == 3'd7) begin
                            bit_q   <= '0;
`ifdef UART_TX_PARITY_EN
                            state_q <= S_PARITY;
                            tx_q    <= par_q;
`else
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end_c) begin
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end_c) begin
                        if (!last_char_c) begin
                            state_q <= S_START;
                            tx_q    <= 1'b0;
                            idx_q   <= idx_q + IDX_W'(1);
                            shift_q <= next_char_c;
`ifdef UART_TX_PARITY_EN
                            par_q   <= ^next_char_c;
`endif
                        end else begin
                            state_q <= S_IDLE;
                            tx_q    <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            idx_q   <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign byte_idx = idx_q;

endmodule
